// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers hex nibbles from a multiplexed active-low
// 4-digit 7-segment bus once each {an_in, seg_in} pattern has settled.
//
// Parameters:
//   STABLE_CYCLES  cycles a sampled pattern must hold before capture (2..255)
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   seg_in[6:0] segment lines, active-low, bit0 = a .. bit6 = g
//   an_in[3:0]  anode enables, active-low, an_in[i]=0 selects digit i
//   digits[15:0] recovered nibbles, digits[4i+3:4i] = digit i
//   valid[3:0]  digit i holds a decoded hex value
//   err[3:0]    last capture of digit i was an unrecognised pattern
//   update      one-cycle pulse on every qualified capture
//   upd_idx     digit index of the most recent capture
//   frame_done  one-cycle pulse once all four digits have been captured
// Build option:
//   SEG7_SYNC_EN  defined: two-flop synchronizer on all 11 input bits
//                 undefined: single register stage (inputs synchronous)

module seg7_scan_decoder #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  seg_in,
   input  logic [3:0]  an_in,
   output logic [15:0] digits,
   output logic [3:0]  valid,
   output logic [3:0]  err,
   output logic        update,
   output logic [1:0]  upd_idx,
   output logic        frame_done
);

   typedef enum logic {
      SETTLE = 1'b0,
      HOLD   = 1'b1
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);
   localparam logic [7:0] CNT_MAX  = 8'hFF;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // ------------------------------------------------------------
   // Input stage: S is the registered bus, P is S one cycle later.
   // Idle display (all lines high) is the reset value so that a
   // pattern held through reset is still seen as a fresh change.
   // ------------------------------------------------------------
   logic [10:0] s_q;
   logic [10:0] p_q;

`ifdef SEG7_SYNC_EN
   logic [10:0] meta_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= '1;
         s_q    <= '1;
      end else begin
         meta_q <= {an_in, seg_in};
         s_q    <= meta_q;
      end
   end
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_q <= '1;
      end else begin
         s_q <= {an_in, seg_in};
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_q <= '1;
      end else begin
         p_q <= s_q;
      end
   end

   logic       same;
   logic [3:0] s_an;
   logic [6:0] s_seg;

   assign same  = (s_q == p_q);
   assign s_an  = s_q[10:7];
   assign s_seg = s_q[6:0];

   // ------------------------------------------------------------
   // Stability counter: restarts on any change, saturates so a
   // long-held pattern never wraps back into a second capture.
   // ------------------------------------------------------------
   logic [7:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (!same) begin
         cnt_q <= '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_q <= cnt_q + 8'd1;
      end
   end

   // ------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------
   state_t state_q;
   state_t state_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SETTLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         SETTLE: begin
            if (same && (cnt_q == CNT_LAST)) begin
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (!same) begin
               state_d = SETTLE;
            end
         end
         default: state_d = SETTLE;
      endcase
   end

   // ------------------------------------------------------------
   // Anode qualification: exactly one low line selects a digit.
   // ------------------------------------------------------------
   logic       sel_ok;
   logic [1:0] sel;

   always_comb begin
      sel_ok = 1'b1;
      sel    = 2'd0;
      case (s_an)
         4'b1110: sel = 2'd0;
         4'b1101: sel = 2'd1;
         4'b1011: sel = 2'd2;
         4'b0111: sel = 2'd3;
         default: sel_ok = 1'b0;
      endcase
   end

   // ------------------------------------------------------------
   // Segment decode, patterns written g..a.
   // ------------------------------------------------------------
   logic       hit;
   logic [3:0] nib;

   always_comb begin
      hit = 1'b1;
      nib = 4'h0;
      case (s_seg)
         7'b1000000: nib = 4'h0;
         7'b1111001: nib = 4'h1;
         7'b0100100: nib = 4'h2;
         7'b0110000: nib = 4'h3;
         7'b0011001: nib = 4'h4;
         7'b0010010: nib = 4'h5;
         7'b0000010: nib = 4'h6;
         7'b1111000: nib = 4'h7;
         7'b0000000: nib = 4'h8;
         7'b0010000: nib = 4'h9;
         7'b0001000: nib = 4'hA;
         7'b0000011: nib = 4'hB;
         7'b1000110: nib = 4'hC;
         7'b0100001: nib = 4'hD;
         7'b0000110: nib = 4'hE;
         7'b0001110: nib = 4'hF;
         default:    hit = 1'b0;
      endcase
   end

   // ------------------------------------------------------------
   // FSM: outputs. Capture happens only on the SETTLE->HOLD edge,
   // so each stable window yields at most one capture.
   // ------------------------------------------------------------
   logic        capture;
   logic        qcap;
   logic [3:0]  mask_q;
   logic [3:0]  mask_d;
   logic [3:0]  mask_set;
   logic [15:0] digits_d;
   logic [3:0]  valid_d;
   logic [3:0]  err_d;
   logic [1:0]  idx_d;
   logic        upd_d;
   logic        fd_d;

   assign capture = (state_q == SETTLE) && (state_d == HOLD);
   assign qcap    = capture && sel_ok;

   always_comb begin
      digits_d = digits;
      valid_d  = valid;
      err_d    = err;
      idx_d    = upd_idx;
      mask_d   = mask_q;
      mask_set = mask_q | (4'b0001 << sel);
      upd_d    = 1'b0;
      fd_d     = 1'b0;
      if (qcap) begin
         upd_d = 1'b1;
         idx_d = sel;
         if (hit) begin
            digits_d[{sel, 2'b00} +: 4] = nib;
            valid_d[sel] = 1'b1;
            err_d[sel]   = 1'b0;
         end else if (s_seg == SEG_BLANK) begin
            valid_d[sel] = 1'b0;
            err_d[sel]   = 1'b0;
         end else begin
            err_d[sel]   = 1'b1;
         end
         // Frame completes on the capture that fills the mask.
         if (mask_set == 4'hF) begin
            fd_d   = 1'b1;
            mask_d = 4'h0;
         end else begin
            mask_d = mask_set;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digits     <= '0;
         valid      <= '0;
         err        <= '0;
         upd_idx    <= '0;
         update     <= 1'b0;
         frame_done <= 1'b0;
         mask_q     <= '0;
      end else begin
         digits     <= digits_d;
         valid      <= valid_d;
         err        <= err_d;
         upd_idx    <= idx_d;
         update     <= upd_d;
         frame_done <= fd_d;
         mask_q     <= mask_d;
      end
   end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed vector table plus latency and
// reset sequences for seg7_scan_decoder.

module tb_seg7_scan_decoder;

   localparam int ST = 4;
`ifdef SEG7_SYNC_EN
   localparam int LAT = ST + 2;
`else
   localparam int LAT = ST + 1;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  seg_in;
   logic [3:0]  an_in;
   logic [15:0] digits;
   logic [3:0]  valid;
   logic [3:0]  err;
   logic        update;
   logic [1:0]  upd_idx;
   logic        frame_done;

   always #5 clk = ~clk;

   seg7_scan_decoder #(.STABLE_CYCLES(ST)) dut (
      .clk        (clk),
      .rst        (rst),
      .seg_in     (seg_in),
      .an_in      (an_in),
      .digits     (digits),
      .valid      (valid),
      .err        (err),
      .update     (update),
      .upd_idx    (upd_idx),
      .frame_done (frame_done)
   );

   typedef struct {
      logic [3:0]  an;
      logic [6:0]  seg;
      int          hold;
      int          upd;
      logic [1:0]  idx;
      int          fd;
      logic [15:0] dig;
      logic [3:0]  val;
      logic [3:0]  er;
   } vec_t;

   vec_t tbl[$];

   int napplied = 0;
   int nmis     = 0;
   int nupd;
   int nfd;
   int nbad     = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      napplied++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One clock; sample #1 after the edge. Flags pulses without
   // update and data changes outside update cycles.
   task automatic tick();
      logic [15:0] pd;
      logic [3:0]  pv;
      logic [3:0]  pe;
      pd = digits;
      pv = valid;
      pe = err;
      @(posedge clk);
      #1;
      if (update) nupd++;
      if (frame_done) nfd++;
      if (frame_done && !update) nbad++;
      if (!update && (digits !== pd || valid !== pv || err !== pe))
         nbad++;
   endtask

   task automatic measure(output int lat);
      lat  = -1;
      nupd = 0;
      for (int t = 0; t < 50; t++) begin
         tick();
         if (nupd != 0) begin
            lat = t;
            break;
         end
      end
   endtask

   task automatic add(input logic [3:0] an, input logic [6:0] seg,
                      input int hold, input int upd, input logic [1:0] idx,
                      input int fd, input logic [15:0] dig,
                      input logic [3:0] val, input logic [3:0] er);
      vec_t v;
      v.an = an; v.seg = seg; v.hold = hold; v.upd = upd; v.idx = idx;
      v.fd = fd; v.dig = dig; v.val = val; v.er = er;
      tbl.push_back(v);
   endtask

   initial begin
      int lat;
      string nm;

      add(4'b1110, 7'b0100100,  10, 1, 2'd0, 0, 16'h0002, 4'b0001, 4'b0000);
      add(4'b1101, 7'b0000110,   3, 0, 2'd0, 0, 16'h0002, 4'b0001, 4'b0000);
      add(4'b1111, 7'b0000110,  10, 0, 2'd0, 0, 16'h0002, 4'b0001, 4'b0000);
      add(4'b1101, 7'b0000110,  10, 1, 2'd1, 0, 16'h00E2, 4'b0011, 4'b0000);
      add(4'b1011, 7'b0001000,  10, 1, 2'd2, 0, 16'h0AE2, 4'b0111, 4'b0000);
      add(4'b1011, 7'b0101010,  10, 1, 2'd2, 0, 16'h0AE2, 4'b0111, 4'b0100);
      add(4'b1011, 7'b1111111,  10, 1, 2'd2, 0, 16'h0AE2, 4'b0011, 4'b0000);
      add(4'b1100, 7'b0000000,  20, 0, 2'd2, 0, 16'h0AE2, 4'b0011, 4'b0000);
      add(4'b1110, 7'b1111001,   8, 1, 2'd0, 0, 16'h0AE1, 4'b0011, 4'b0000);
      add(4'b1101, 7'b0100100,   8, 1, 2'd1, 0, 16'h0A21, 4'b0011, 4'b0000);
      add(4'b1011, 7'b0110000,   8, 1, 2'd2, 0, 16'h0321, 4'b0111, 4'b0000);
      add(4'b0111, 7'b0001110,   8, 1, 2'd3, 1, 16'hF321, 4'b1111, 4'b0000);
      add(4'b1110, 7'b0010010,   8, 1, 2'd0, 0, 16'hF325, 4'b1111, 4'b0000);
      add(4'b1101, 7'b0000000,  ST, 0, 2'd0, 0, 16'hF325, 4'b1111, 4'b0000);
      add(4'b1110, 7'b0000000, 300, 1, 2'd0, 0, 16'hF328, 4'b1111, 4'b0000);
      add(4'b1101, 7'b1110111,  10, 1, 2'd1, 0, 16'hF328, 4'b1111, 4'b0010);
      add(4'b1111, 7'b1111111,  10, 0, 2'd1, 0, 16'hF328, 4'b1111, 4'b0010);

      rst    = 1'b1;
      an_in  = 4'b1111;
      seg_in = 7'b1111111;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst_digits", digits, 16'h0);
      check("rst_valid", valid, 4'h0);
      check("rst_err", err, 4'h0);
      check("rst_pulses", {update, frame_done, upd_idx}, 4'h0);
      rst = 1'b0;

      foreach (tbl[k]) begin
         an_in  = tbl[k].an;
         seg_in = tbl[k].seg;
         nupd   = 0;
         nfd    = 0;
         for (int c = 0; c < tbl[k].hold; c++) tick();
         nm = $sformatf("v%0d", k);
         check({nm, "_update"}, nupd, tbl[k].upd);
         check({nm, "_fdone"}, nfd, tbl[k].fd);
         check({nm, "_idx"}, upd_idx, tbl[k].idx);
         check({nm, "_digits"}, digits, tbl[k].dig);
         check({nm, "_valid"}, valid, tbl[k].val);
         check({nm, "_err"}, err, tbl[k].er);
      end

      // Capture latency from the first edge that sees the pattern.
      an_in  = 4'b1011;
      seg_in = 7'b0010000;
      measure(lat);
      check("latency", lat, LAT);
      check("lat_idx", upd_idx, 2'd2);
      check("lat_digits", digits, 16'hF928);
      check("lat_valid", valid, 4'b1111);
      check("lat_err", err, 4'b0010);
      an_in  = 4'b1111;
      seg_in = 7'b1111111;
      for (int c = 0; c < 10; c++) tick();

      // Reset mid-window on digit 1 clears everything at once.
      an_in  = 4'b1101;
      seg_in = 7'b1111000;
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("async_digits", digits, 16'h0);
      check("async_flags", {valid, err}, 8'h0);
      check("async_idx", {update, frame_done, upd_idx}, 4'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      measure(lat);
      check("rst_latency", lat, LAT);
      check("rst_idx", upd_idx, 2'd1);
      check("rst_cap_digits", digits, 16'h0070);
      check("rst_cap_valid", valid, 4'b0010);
      check("rst_cap_err", err, 4'b0000);
      nfd = 0;
      for (int c = 0; c < 10; c++) tick();
      check("rst_no_frame", nfd, 0);

      check("pulse_rules", nbad, 0);

      $display("== %0d vectors applied, %0d miscompares ==", napplied, nmis);
      $finish;
   end

endmodule
